// File: rtl/irq_controller.sv
// N-channel vectored interrupt controller.
// Raw sources are synchronised, polarity-normalised and latched as pending
// (edge or level per channel). A fixed-priority arbiter, gated by the
// in-service threshold, feeds a three-state request FSM toward the core.
// Handshake: irq_req is held with irq_id/irq_vector stable until the core
// pulses irq_ack in a cycle where irq_req=1; an ack in any other cycle is
// ignored, and irq_req may be withdrawn if the latched channel stops being
// eligible before it is acknowledged.
module irq_controller #(
    parameter int                  NUM_IRQ       = 8,
    parameter int                  PC_WIDTH      = 9,
    parameter logic [PC_WIDTH-1:0] VECTOR_BASE   = 9'h1F0,
    parameter int                  VECTOR_STRIDE = 2,
    localparam int                 ID_W          = $clog2(NUM_IRQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_addr,
    input  logic [NUM_IRQ-1:0]  cfg_wdata,
    output logic [NUM_IRQ-1:0]  cfg_rdata,
    input  logic                irq_ack,
    input  logic                reti,
    output logic                irq_req,
    output logic [ID_W-1:0]     irq_id,
    output logic [PC_WIDTH-1:0] irq_vector,
    output logic [NUM_IRQ-1:0]  in_service,
    output logic [1:0]          dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [NUM_IRQ-1:0]   s1_q, s2_q, s3_q;
    logic [NUM_IRQ-1:0]   enable_q, enable_d;
    logic [NUM_IRQ-1:0]   mode_q, mode_d;
    logic [NUM_IRQ-1:0]   pol_q, pol_d;
    logic [NUM_IRQ-1:0]   pend_q, pend_d;
    logic [NUM_IRQ-1:0]   insvc_q, insvc_d;

    logic [NUM_IRQ-1:0]   act, act_dly, rise, w1c;
    logic [NUM_IRQ-1:0]   below_thr, eligible, ack_onehot, insvc_lowest;
    logic [ID_W-1:0]      winner;
    logic                 any_elig, ack_fire;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= irq_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Normalise polarity so that 1 always means "active"; both samples use
    // the current polarity so a polarity change never fakes an edge.
    assign act     = ~(s2_q ^ pol_q);
    assign act_dly = ~(s3_q ^ pol_q);
    assign rise    = act & ~act_dly;

    // Configuration register write decode; addr 3 only produces clear bits.
    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        pol_d    = pol_q;
        w1c      = '0;
        if (cfg_we) begin
            case (cfg_addr)
                2'd0:    enable_d = cfg_wdata;
                2'd1:    mode_d   = cfg_wdata;
                2'd2:    pol_d    = cfg_wdata;
                default: w1c      = cfg_wdata;
            endcase
        end
    end

    // Combinational readback of the selected configuration register.
    always_comb begin
        case (cfg_addr)
            2'd0:    cfg_rdata = enable_q;
            2'd1:    cfg_rdata = mode_q;
            2'd2:    cfg_rdata = pol_q;
            default: cfg_rdata = pend_q;
        endcase
    end

    // Threshold mask (indices strictly below the lowest in-service bit) and
    // lowest-index winner among eligible channels.
    always_comb begin
        logic seen;
        seen      = 1'b0;
        below_thr = '0;
        winner    = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            seen         = seen | insvc_q[i];
            below_thr[i] = ~seen;
        end
        eligible = pend_q & enable_q & below_thr;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end
        any_elig = |eligible;
    end

    assign ack_fire     = (state_q == ST_REQ) && irq_ack;
    assign ack_onehot   = ack_fire ? ({{(NUM_IRQ-1){1'b0}}, 1'b1} << id_q) : '0;
    assign insvc_lowest = insvc_q & (~insvc_q + NUM_IRQ'(1));

    // Pending update: edge channels set on rise (set beats clear), level
    // channels simply follow the normalised input.
    assign pend_d = (mode_q & (rise | (pend_q & ~(w1c | ack_onehot))))
                  | (~mode_q & act);

    // reti retires the pre-ack innermost level, then the ack bit is added.
    assign insvc_d = (reti ? (insvc_q & ~insvc_lowest) : insvc_q) | ack_onehot;

    // Request FSM next-state and request output.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        irq_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_elig) begin
                    id_d    = winner;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                irq_req = 1'b1;
                if (irq_ack)              state_d = ST_HOLD;
                else if (!eligible[id_q]) state_d = ST_IDLE;
            end
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            id_q     <= '0;
            enable_q <= '0;
            mode_q   <= '0;
            pol_q    <= '0;
            pend_q   <= '0;
            insvc_q  <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            enable_q <= enable_d;
            mode_q   <= mode_d;
            pol_q    <= pol_d;
            pend_q   <= pend_d;
            insvc_q  <= insvc_d;
        end
    end

    assign irq_id      = id_q;
    assign irq_vector  = VECTOR_BASE + PC_WIDTH'(id_q) * PC_WIDTH'(VECTOR_STRIDE);
    assign in_service  = insvc_q;
    assign dbg_state_o = state_q;

endmodule
